cnn_layer1_fmap_buffer: RTL and testbench

Ping-pong feature-map buffer directly downstream of the layer-1 channel pipeline (conv 3x3 -> pool 2x2 -> pool 2x2, 16x16 output per frame). Captures one full 16x16 output map, applies optional ReLU, and replays it to the layer-2 reader over a valid/ready stream. The upstream stage carries no backpressure, so this block absorbs whole frames and flags overflow. It drives the upstream stage's NEXT_LAST_PIX.

---
 rtl/cnn_layer1_fmap_buffer.sv | 169 ++++++++++++++++
 tb/tb_cnn_layer1_fmap_buffer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer1_fmap_buffer.sv
// Ping-pong 16x16 feature-map buffer between the layer-1 pipeline and the layer-2 reader.
// Absorbs whole frames without backpressure, optionally applies ReLU, and replays over valid/ready.
module cnn_layer1_fmap_buffer #(
  parameter int P_WIDTH     = 16,
  parameter int P_HEIGHT    = 16,
  parameter int P_PIX_CNT_W = 8,
  parameter int DW          = 24,
  parameter bit RELU_EN     = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 DIN_VALID,
  input  logic signed [DW-1:0] DIN,
  input  logic                 DIN_LAST_IN_LINE,
  input  logic                 DIN_LAST_PIX,
  output logic                 LAST_PIX,
  output logic signed [DW-1:0] RD_OUT,
  output logic                 RD_VALID,
  input  logic                 RD_READY,
  output logic                 RD_LAST_IN_LINE,
  output logic                 RD_LAST_PIX,
  output logic [1:0]           FULL_CNT,
  output logic                 OVERFLOW,
  output logic                 FRAME_ERR
);

  localparam int N = P_WIDTH * P_HEIGHT;
  localparam logic [P_PIX_CNT_W-1:0] LAST_ADDR = P_PIX_CNT_W'(N - 1);

  typedef enum logic [1:0] {RD_IDLE, RD_FETCH, RD_STREAM} rd_state_e;

  function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] x);
    if (RELU_EN && x[DW-1]) return '0;
    return x;
  endfunction

  function automatic logic is_eol(input logic [P_PIX_CNT_W-1:0] c);
    return (int'(c) % P_WIDTH) == (P_WIDTH - 1);
  endfunction

  logic signed [DW-1:0] mem [2*N];

  logic                   wr_bank_q, wr_bank_d;
  logic [P_PIX_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic                   rd_bank_q, rd_bank_d;
  logic [P_PIX_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [1:0]             bank_full_q, bank_full_d;
  logic [1:0]             full_cnt_q, full_cnt_d;
  logic                   last_pix_q, last_pix_d;
  logic                   overflow_q, overflow_d;
  logic                   frame_err_q, frame_err_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   rd_lil_q, rd_lil_d;
  logic                   rd_lp_q, rd_lp_d;
  rd_state_e              rd_state_q, rd_state_d;
  logic signed [DW-1:0]   rd_out_q;

  logic wr_acc, wr_at_end, commit, rd_acc, rd_free;

  always_comb begin
    wr_acc    = DIN_VALID && !bank_full_q[wr_bank_q];
    wr_at_end = (wr_cnt_q == LAST_ADDR);
    commit    = wr_acc && (DIN_LAST_PIX || wr_at_end);
    rd_acc    = rd_valid_q && RD_READY;
    rd_free   = rd_acc && (rd_cnt_q == LAST_ADDR);

    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    rd_state_d  = rd_state_q;
    rd_valid_d  = rd_valid_q;
    bank_full_d = bank_full_q;

    if (wr_acc) begin
      wr_cnt_d = commit ? '0 : wr_cnt_q + 1'b1;
      if (commit) wr_bank_d = ~wr_bank_q;
    end

    // Write bank can only be full when both banks are full, since banks fill and drain in order
    last_pix_d  = commit;
    overflow_d  = overflow_q || (DIN_VALID && bank_full_q[wr_bank_q]);
    frame_err_d = frame_err_q || (wr_acc && ((DIN_LAST_PIX != wr_at_end) ||
                                             (DIN_LAST_IN_LINE != is_eol(wr_cnt_q))));
    if (commit)  bank_full_d[wr_bank_q] = 1'b1;
    if (rd_free) bank_full_d[rd_bank_q] = 1'b0;
    full_cnt_d = full_cnt_q + {1'b0, commit} - {1'b0, rd_free};

    case (rd_state_q)
      RD_IDLE: begin
        rd_cnt_d = '0;
        if (bank_full_q[rd_bank_q]) rd_state_d = RD_FETCH;
      end
      RD_FETCH: begin
        rd_state_d = RD_STREAM;
        rd_valid_d = 1'b1;
      end
      RD_STREAM: begin
        if (rd_free) begin
          rd_state_d = RD_IDLE;
          rd_valid_d = 1'b0;
          rd_bank_d  = ~rd_bank_q;
          rd_cnt_d   = '0;
        end else if (rd_acc) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: begin
        rd_state_d = RD_IDLE;
        rd_valid_d = 1'b0;
      end
    endcase

    rd_lil_d = rd_valid_d && is_eol(rd_cnt_d);
    rd_lp_d  = rd_valid_d && (rd_cnt_d == LAST_ADDR);
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) mem[{wr_bank_q, wr_cnt_q}] <= relu(DIN);
  end

  // Read port re-reads the held address while stalled, so accepting always has the next word ready
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) rd_out_q <= '0;
    else       rd_out_q <= mem[{rd_bank_q, rd_cnt_d}];
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      bank_full_q <= '0;
      full_cnt_q  <= '0;
      last_pix_q  <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_lil_q    <= 1'b0;
      rd_lp_q     <= 1'b0;
      rd_state_q  <= RD_IDLE;
    end else begin
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      bank_full_q <= bank_full_d;
      full_cnt_q  <= full_cnt_d;
      last_pix_q  <= last_pix_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      rd_valid_q  <= rd_valid_d;
      rd_lil_q    <= rd_lil_d;
      rd_lp_q     <= rd_lp_d;
      rd_state_q  <= rd_state_d;
    end
  end

  assign LAST_PIX        = last_pix_q;
  assign RD_OUT          = rd_out_q;
  assign RD_VALID        = rd_valid_q;
  assign RD_LAST_IN_LINE = rd_lil_q;
  assign RD_LAST_PIX     = rd_lp_q;
  assign FULL_CNT        = full_cnt_q;
  assign OVERFLOW        = overflow_q;
  assign FRAME_ERR       = frame_err_q;

endmodule

// File: tb/tb_cnn_layer1_fmap_buffer.sv
// Scoreboard bench for cnn_layer1_fmap_buffer: frame-level reference model feeds an expected-beat
// queue; a monitor pops and compares each accepted read beat.
module tb_cnn_layer1_fmap_buffer;
  localparam int DW = 24;
  localparam int NPIX = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, din_valid, din_lil, din_lp, rd_ready;
  logic [DW-1:0] din;
  logic last_pix, rd_valid, rd_lil, rd_lp, overflow, frame_err;
  logic [DW-1:0] rd_out;
  logic [1:0] full_cnt;
  logic last_pix_raw, rd_valid_raw, rd_lil_raw, rd_lp_raw, overflow_raw, frame_err_raw;
  logic [DW-1:0] rd_out_raw;
  logic [1:0] full_cnt_raw;

  cnn_layer1_fmap_buffer #(.RELU_EN(1'b1)) dut (
    .CLK(clk), .RSTn(rst_n), .DIN_VALID(din_valid), .DIN(din),
    .DIN_LAST_IN_LINE(din_lil), .DIN_LAST_PIX(din_lp), .LAST_PIX(last_pix),
    .RD_OUT(rd_out), .RD_VALID(rd_valid), .RD_READY(rd_ready),
    .RD_LAST_IN_LINE(rd_lil), .RD_LAST_PIX(rd_lp), .FULL_CNT(full_cnt),
    .OVERFLOW(overflow), .FRAME_ERR(frame_err));

  cnn_layer1_fmap_buffer #(.RELU_EN(1'b0)) dut_raw (
    .CLK(clk), .RSTn(rst_n), .DIN_VALID(din_valid), .DIN(din),
    .DIN_LAST_IN_LINE(din_lil), .DIN_LAST_PIX(din_lp), .LAST_PIX(last_pix_raw),
    .RD_OUT(rd_out_raw), .RD_VALID(rd_valid_raw), .RD_READY(rd_ready),
    .RD_LAST_IN_LINE(rd_lil_raw), .RD_LAST_PIX(rd_lp_raw), .FULL_CNT(full_cnt_raw),
    .OVERFLOW(overflow_raw), .FRAME_ERR(frame_err_raw));

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] w;
    bit care;
    bit lil;
    bit lp;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state: bank contents as seen by the reader, plus frame-level bookkeeping
  logic [DW-1:0] mem_r [2][NPIX];
  logic [DW-1:0] mem_w [2][NPIX];
  bit care_m [2][NPIX];
  int m_full = 0, m_wb = 0, m_wc = 0;
  bit m_ovf = 0, m_ferr = 0;
  bit pending_commit = 0;
  logic exp_lp = 1'b0;
  int lp_pulses = 0;
  int ready_mode = 1;

  int beat_idx = 0, last_cyc = -1, first_cyc = 0, frame_last_cyc = 0, last_gap = 0;
  bit armed = 0;
  logic [DW-1:0] stall_val;
  exp_t mon_e;
  exp_t drv_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [DW-1:0] relu_m(input logic [DW-1:0] v);
    return ($signed(v) < 0) ? '0 : v;
  endfunction

  task automatic cycle(input bit v, input logic [DW-1:0] d, input bit lil, input bit lp);
    @(posedge clk);
    #1;
    din_valid = v; din = d; din_lil = lil; din_lp = lp;
    pending_commit = 0;
    if (v) begin
      if (m_full < 2) begin
        mem_r[m_wb][m_wc] = relu_m(d);
        mem_w[m_wb][m_wc] = d;
        care_m[m_wb][m_wc] = 1'b1;
        if ((lp != (m_wc == NPIX - 1)) || (lil != ((m_wc % 16) == 15))) m_ferr = 1;
        if (lp || m_wc == NPIX - 1) begin
          for (int k = 0; k < NPIX; k++) begin
            drv_e.r = mem_r[m_wb][k];
            drv_e.w = mem_w[m_wb][k];
            drv_e.care = care_m[m_wb][k];
            drv_e.lil = (k % 16) == 15;
            drv_e.lp = (k == NPIX - 1);
            exp_q.push_back(drv_e);
          end
          m_full++;
          m_wb ^= 1;
          m_wc = 0;
          pending_commit = 1;
        end else begin
          m_wc++;
        end
      end else begin
        m_ovf = 1;
      end
    end
  endtask

  task automatic send_frame(input int kind, input int base, input int npix);
    logic [DW-1:0] d;
    for (int i = 0; i < npix; i++) begin
      case (kind)
        0: d = DW'(base + i);
        1: d = (i % 2 == 0) ? 24'hFFFFF0 : 24'h000100;
        default: d = DW'($urandom());
      endcase
      cycle(1'b1, d, (i % 16) == 15, i == npix - 1);
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rd_valid) done = 1;
    end
    check("drain_done", done, 1);
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_last_pix"}, last_pix, 0);
    check({tag, "_rd_out"}, rd_out, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_lil"}, rd_lil, 0);
    check({tag, "_rd_lp"}, rd_lp, 0);
    check({tag, "_full_cnt"}, full_cnt, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_raw_valid"}, rd_valid_raw, 0);
  endtask

  initial begin
    rd_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: rd_ready = 1'b0;
        1: rd_ready = 1'b1;
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  initial forever begin
    @(posedge clk);
    exp_lp = pending_commit;
    pending_commit = 0;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check("last_pix", last_pix, exp_lp);
      if (last_pix) lp_pulses++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      beat_idx = 0; armed = 0; last_cyc = -1;
    end else if (rd_valid) begin
      if (armed) check("stall_hold", rd_out, stall_val);
      if (rd_ready) begin
        if (exp_q.size() == 0) begin
          check("beat_expected", 0, 1);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.care) begin
            check("rd_out", rd_out, mon_e.r);
            check("rd_out_raw", rd_out_raw, mon_e.w);
          end
          check("raw_valid", rd_valid_raw, 1);
          check("rd_last_in_line", rd_lil, mon_e.lil);
          check("rd_last_pix", rd_lp, mon_e.lp);
          if (beat_idx == 0) begin
            first_cyc = cyc;
            if (last_cyc >= 0) last_gap = cyc - last_cyc;
          end
          beat_idx++;
          if (mon_e.lp) begin
            frame_last_cyc = cyc;
            last_cyc = cyc;
            beat_idx = 0;
            m_full--;
          end
        end
        armed = 0;
      end else begin
        armed = 1;
        stall_val = rd_out;
      end
    end else begin
      armed = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bit hit;
    for (int b = 0; b < 2; b++)
      for (int k = 0; k < NPIX; k++) care_m[b][k] = 1'b0;
    rst_n = 1'b0; din_valid = 1'b0; din = '0; din_lil = 1'b0; din_lp = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Single ramp frame with the reader always ready
    ready_mode = 1;
    send_frame(0, 0, NPIX);
    cycle(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("full_after_commit", full_cnt, 1);
    check("valid_commit_p1", rd_valid, 0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("valid_commit_p2", rd_valid, 0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("valid_commit_p3", rd_valid, 1);
    wait_drain(600);
    check("burst_len", frame_last_cyc - first_cyc, NPIX - 1);
    check("full_after_drain", full_cnt, 0);
    check("overflow_clean", overflow, 0);
    check("frame_err_clean", frame_err, 0);

    // ReLU on alternating negative/positive words
    send_frame(1, 0, NPIX);
    cycle(1'b0, '0, 1'b0, 1'b0);
    wait_drain(600);

    // Random backpressure with random data
    ready_mode = 2;
    send_frame(2, 0, NPIX);
    cycle(1'b0, '0, 1'b0, 1'b0);
    wait_drain(4000);

    // Three frames into a stalled reader: third is dropped
    ready_mode = 0;
    p0 = lp_pulses;
    send_frame(0, 1000, NPIX);
    send_frame(0, 2000, NPIX);
    send_frame(0, 3000, NPIX);
    cycle(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("full_two", full_cnt, 2);
    check("overflow_set", overflow, m_ovf);
    check("overflow_set_raw", overflow_raw, 1);
    check("lp_pulse_count", lp_pulses - p0, 2);
    check("frame_err_ovf", frame_err, m_ferr);
    ready_mode = 1;
    wait_drain(1500);
    check("frame_gap", last_gap, 3);

    // Short frame: last pixel marker on pixel 200
    send_frame(0, 500, 200);
    cycle(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    check("frame_err_short", frame_err, m_ferr);
    check("frame_err_short_set", frame_err, 1);
    send_frame(0, 700, NPIX);
    cycle(1'b0, '0, 1'b0, 1'b0);
    wait_drain(1500);
    check("frame_err_sticky", frame_err, 1);

    // Asynchronous reset in the middle of a replay
    send_frame(2, 0, NPIX);
    cycle(1'b0, '0, 1'b0, 1'b0);
    hit = 0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(posedge clk);
      if (beat_idx >= 100) hit = 1;
    end
    check("reached_beat_100", hit, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    m_full = 0; m_wb = 0; m_wc = 0; m_ovf = 0; m_ferr = 0;
    pending_commit = 0; exp_lp = 1'b0;
    #1;
    chk_zero("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(0, 4000, NPIX);
    cycle(1'b0, '0, 1'b0, 1'b0);
    wait_drain(700);
    check("post_reset_full", full_cnt, 0);
    check("post_reset_overflow", overflow, 0);
    check("post_reset_frame_err", frame_err, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
